ama_riscv_load_req_ctrl: RTL and testbench

AMA_RISCV_LOAD_REQ_CTRL -- requirements
Module: ama_riscv_load_req_ctrl

---
 rtl/ama_riscv_load_req_ctrl_pkg.sv | 42 ++++
 rtl/ama_riscv_load_align_chk.sv | 25 ++
 rtl/ama_riscv_load_req_ctrl.sv | 123 ++++++++++++
 tb/tb_ama_riscv_load_req_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_load_req_ctrl_pkg.sv
// Shared types and constants for the load request controller and its alignment checker.
package ama_riscv_load_req_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 2;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // RV32I load funct3 encodings
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Access width carried in funct3[1:0]
  localparam logic [1:0] WID_BYTE = 2'b00;
  localparam logic [1:0] WID_HALF = 2'b01;
  localparam logic [1:0] WID_WORD = 2'b10;

  // Request context handed to load_shift_mask
  typedef struct packed {
    logic [F3_W-1:0]  funct3;
    logic [OFF_W-1:0] offset;
  } load_ctx_t;

  function automatic logic f3_legal(input logic [F3_W-1:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ama_riscv_load_align_chk.sv
// Combinational legality/alignment check for an RV32I load request.
module ama_riscv_load_align_chk
  import ama_riscv_load_req_ctrl_pkg::*;
(
  input  logic [OFF_W-1:0] addr,
  input  logic [F3_W-1:0]  funct3,
  output logic             misaligned
);

  logic [1:0] wid;
  assign wid = funct3[1:0];

  // Bytes never fault; halfwords may not straddle the word; words must be aligned
  always_comb begin
    misaligned = 1'b0;
    if (!f3_legal(funct3)) begin
      misaligned = 1'b1;
    end else if ((wid == WID_HALF) && (addr == 2'd3)) begin
      misaligned = 1'b1;
    end else if ((wid == WID_WORD) && (addr != 2'd0)) begin
      misaligned = 1'b1;
    end
  end

endmodule

// File: rtl/ama_riscv_load_req_ctrl.sv
// Load request controller: accepts EX-stage loads, issues word reads and forwards data to load_shift_mask.
module ama_riscv_load_req_ctrl
  import ama_riscv_load_req_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [F3_W-1:0]  req_funct3,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic             lsm_en,
  output logic [OFF_W-1:0] lsm_offset,
  output logic [F3_W-1:0]  lsm_width,
  output logic [XLEN-1:0]  lsm_data,
  output logic             misalign,
  output logic             spurious_rsp
);

  state_t          state, state_nxt;
  load_ctx_t       ctx, ctx_nxt;
  logic            mem_req_valid_nxt;
  logic [XLEN-1:0] mem_addr_nxt;
  logic            lsm_en_nxt;
  logic [XLEN-1:0] lsm_data_nxt;
  logic            misalign_nxt;
  logic            spurious_nxt;
  logic            misaligned_c;
  logic            accept_c;

  ama_riscv_load_align_chk u_align_chk (
    .addr       (req_addr[1:0]),
    .funct3     (req_funct3),
    .misaligned (misaligned_c)
  );

  // Ready must follow flush within the cycle and stay low while reset is held
  assign req_ready = rst_n && (state == ST_IDLE) && !flush;
  assign accept_c  = req_valid && req_ready;

  assign lsm_offset = ctx.offset;
  assign lsm_width  = ctx.funct3;

  always_comb begin
    state_nxt     = state;
    ctx_nxt       = ctx;
    mem_addr_nxt  = mem_addr;
    lsm_en_nxt    = 1'b0;
    lsm_data_nxt  = lsm_data;
    misalign_nxt  = 1'b0;
    spurious_nxt  = spurious_rsp;

    case (state)
      ST_IDLE: begin
        if (mem_rsp_valid) spurious_nxt = 1'b1;
        if (accept_c) begin
          if (misaligned_c) begin
            misalign_nxt = 1'b1;
          end else begin
            ctx_nxt.offset = req_addr[1:0];
            ctx_nxt.funct3 = req_funct3;
            mem_addr_nxt   = word_align(req_addr);
            state_nxt      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // A handshake in the flush cycle still leaves a response in flight
        if (mem_rsp_valid) spurious_nxt = 1'b1;
        if (flush) begin
          state_nxt = mem_req_ready ? ST_DRAIN : ST_IDLE;
        end else if (mem_req_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = ST_IDLE;
          if (!flush) begin
            lsm_data_nxt = mem_rsp_data;
            lsm_en_nxt   = 1'b1;
          end
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    mem_req_valid_nxt = (state_nxt == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ctx           <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      lsm_en        <= 1'b0;
      lsm_data      <= '0;
      misalign      <= 1'b0;
      spurious_rsp  <= 1'b0;
    end else begin
      state         <= state_nxt;
      ctx           <= ctx_nxt;
      mem_req_valid <= mem_req_valid_nxt;
      mem_addr      <= mem_addr_nxt;
      lsm_en        <= lsm_en_nxt;
      lsm_data      <= lsm_data_nxt;
      misalign      <= misalign_nxt;
      spurious_rsp  <= spurious_nxt;
    end
  end

endmodule

// File: tb/tb_ama_riscv_load_req_ctrl.sv
// Bench for ama_riscv_load_req_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_ama_riscv_load_req_ctrl;
  import ama_riscv_load_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        lsm_en;
  logic [1:0]  lsm_offset;
  logic [2:0]  lsm_width;
  logic [31:0] lsm_data;
  logic        misalign;
  logic        spurious_rsp;

  always #5 clk = ~clk;

  ama_riscv_load_req_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .lsm_en(lsm_en), .lsm_offset(lsm_offset), .lsm_width(lsm_width), .lsm_data(lsm_data),
    .misalign(misalign), .spurious_rsp(spurious_rsp)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: a request is either on the bus, owed back by memory (kept or discarded), or absent
  bit          m_on_bus, m_owed, m_keep, m_en, m_mis, m_spur;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_off;
  logic [2:0]  m_wid;

  task automatic model_reset();
    m_on_bus = 0; m_owed = 0; m_keep = 0; m_en = 0; m_mis = 0; m_spur = 0;
    m_addr = '0; m_data = '0; m_off = '0; m_wid = '0;
  endtask

  function automatic bit model_idle();
    return !m_on_bus && !m_owed;
  endfunction

  function automatic bit model_bad(input logic [31:0] a, input logic [2:0] f);
    int off  = int'(a[1:0]);
    int size = 1 << int'(f[1:0]);
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
    return (off + size) > 4;
  endfunction

  task automatic model_step(input bit rv, input logic [31:0] a, input logic [2:0] f,
                            input bit fl, input bit rdy, input bit rsp, input logic [31:0] d);
    bit en_n  = 0;
    bit mis_n = 0;
    if (model_idle()) begin
      if (rsp) m_spur = 1;
      if (rv && !fl) begin
        if (model_bad(a, f)) mis_n = 1;
        else begin
          m_off = a[1:0]; m_wid = f; m_addr = a & ~32'd3; m_on_bus = 1;
        end
      end
    end else if (m_on_bus) begin
      if (rsp) m_spur = 1;
      if (rdy) begin
        m_on_bus = 0; m_owed = 1; m_keep = !fl;
      end else if (fl) m_on_bus = 0;
    end else begin
      if (rsp) begin
        m_owed = 0;
        if (m_keep && !fl) begin
          m_data = d; en_n = 1;
        end
      end else if (fl) m_keep = 0;
    end
    m_en = en_n;
    m_mis = mis_n;
  endtask

  task automatic check_regs();
    check("mem_req_valid", 32'(mem_req_valid), 32'(m_on_bus));
    check("mem_addr", mem_addr, m_addr);
    check("lsm_en", 32'(lsm_en), 32'(m_en));
    check("lsm_offset", 32'(lsm_offset), 32'(m_off));
    check("lsm_width", 32'(lsm_width), 32'(m_wid));
    check("lsm_data", lsm_data, m_data);
    check("misalign", 32'(misalign), 32'(m_mis));
    check("spurious_rsp", 32'(spurious_rsp), 32'(m_spur));
  endtask

  task automatic cycle(input bit rv, input logic [31:0] a, input logic [2:0] f,
                       input bit fl, input bit rdy, input bit rsp, input logic [31:0] d);
    @(negedge clk);
    check_regs();
    req_valid = rv; req_addr = a; req_funct3 = f; flush = fl;
    mem_req_ready = rdy; mem_rsp_valid = rsp; mem_rsp_data = d;
    #1;
    check("req_ready", 32'(req_ready), 32'(model_idle() && !fl));
    @(posedge clk);
    model_step(rv, a, f, fl, rdy, rsp, d);
  endtask

  task automatic idle_cyc();
    cycle(0, '0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 0; req_addr = '0; req_funct3 = '0; flush = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_lsm_en", 32'(lsm_en), 32'd0);
    check("rst_lsm_offset", 32'(lsm_offset), 32'd0);
    check("rst_lsm_width", 32'(lsm_width), 32'd0);
    check("rst_lsm_data", lsm_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_spurious", 32'(spurious_rsp), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] legal_f3 [5];

  initial begin
    legal_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    model_reset();
    do_reset();

    // LW 0x1000, immediate ready, response next cycle
    cycle(1, 32'h1000, F3_LW, 0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 0, '0);
    cycle(0, '0, '0, 0, 0, 1, 32'hDEADBEEF);
    #1;
    check("lw_en", 32'(lsm_en), 32'd1);
    check("lw_data", lsm_data, 32'hDEADBEEF);
    check("lw_offset", 32'(lsm_offset), 32'd0);
    check("lw_width", 32'(lsm_width), 32'd2);
    check("lw_addr", mem_addr, 32'h1000);
    idle_cyc();

    // LH at offset 3 is rejected
    cycle(1, 32'h1003, F3_LH, 0, 0, 0, '0);
    #1;
    check("lh_misalign", 32'(misalign), 32'd1);
    check("lh_no_req", 32'(mem_req_valid), 32'd0);
    idle_cyc();
    #1;
    check("lh_pulse_end", 32'(misalign), 32'd0);

    // LBU 0x2002 with memory stalling three cycles
    cycle(1, 32'h2002, F3_LBU, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 0, '0);
    cycle(0, '0, '0, 0, 0, 1, 32'hA5A5_5A5A);
    #1;
    check("lbu_offset", 32'(lsm_offset), 32'd2);
    check("lbu_width", 32'(lsm_width), 32'd4);
    check("lbu_addr", mem_addr, 32'h2000);

    // Flush in WAIT: the late response is dropped
    cycle(1, 32'h3000, F3_LW, 0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 0, '0);
    cycle(0, '0, '0, 1, 0, 0, '0);
    idle_cyc();
    cycle(0, '0, '0, 0, 0, 1, 32'h12345678);
    #1;
    check("flush_no_en", 32'(lsm_en), 32'd0);
    check("flush_data_kept", 32'(lsm_data == 32'h12345678), 32'd0);
    idle_cyc();
    cycle(1, 32'h3004, F3_LW, 0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 0, '0);
    cycle(0, '0, '0, 0, 0, 1, 32'hCAFEF00D);
    #1;
    check("post_flush_en", 32'(lsm_en), 32'd1);
    check("post_flush_data", lsm_data, 32'hCAFEF00D);

    // Spurious response in IDLE is sticky until reset
    do_reset();
    cycle(0, '0, '0, 0, 0, 1, 32'h0BAD0BAD);
    for (int i = 0; i < 5; i++) idle_cyc();
    #1;
    check("spur_sticky", 32'(spurious_rsp), 32'd1);
    do_reset();

    // Reset during WAIT abandons the load
    cycle(1, 32'h4000, F3_LW, 0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 0, '0);
    do_reset();
    cycle(0, '0, '0, 0, 0, 1, 32'h55);
    #1;
    check("late_rsp_spur", 32'(spurious_rsp), 32'd1);
    check("late_rsp_no_en", 32'(lsm_en), 32'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        bit          rv, fl, rdy, rsp;
        logic [31:0] a, d;
        logic [2:0]  f;
        rv  = ($urandom_range(0, 1) == 1);
        a   = $urandom;
        f   = ($urandom_range(0, 7) < 6) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        fl  = ($urandom_range(0, 9) == 0);
        rdy = ($urandom_range(0, 1) == 1);
        rsp = m_owed ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
        d   = $urandom;
        cycle(rv, a, f, fl, rdy, rsp, d);
      end
    end
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
